sipo_deframer: RTL and testbench

- Downstream receiver for the 4-bit PISO serializer's serial output.
- Samples the serial bit stream, framed by a start strobe, and rebuilds the parallel word.
- Presents the rebuilt word on a valid/ready output handshake with a one-word holding register.
- Detects overruns and aborted frames so the link can be checked end-to-end (PISO -> sipo_deframer) in one bench.

---
 rtl/sipo_deframer.sv | 113 +++++++++++
 tb/tb_sipo_deframer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sipo_deframer.sv
`timescale 1ns/1ps
// sipo_deframer
// Receive side of a PISO serial link. The deframer samples sin and rebuilds
// a WIDTH-bit word. The start strobe marks the first bit of each frame.
// The finished word goes into a one-deep holding register with a valid/ready
// handshake. The block also flags two error cases:
//   - overrun: a completed word was dropped because the holding register was full.
//   - abort: a partial frame was discarded because a new start arrived early.
//
// Ports:
//   clk      rising-edge clock, shared with the serializer
//   rst      asynchronous active-high reset
//   sin      serial data in
//   start    frame strobe, high on the edge that samples bit 0 of a frame
//   pout     assembled word, stable while valid=1
//   valid    pout holds an unconsumed word
//   ready    consumer accepts pout on an edge where valid & ready
//   busy     frame in progress (1..WIDTH-1 bits captured)
//   overrun  one-cycle pulse: completed word dropped, holding register full
//   abort    one-cycle pulse: partial frame discarded by an early start
module sipo_deframer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             start,
  output logic [WIDTH-1:0] pout,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overrun,
  output logic             abort
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] pout_q;
  logic             valid_q;
  logic             overrun_q;
  logic             abort_q;

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] sr_d;
  logic             last;

  // A start (from IDLE or as an abort) begins from an empty register.
  // After WIDTH shifts, the first bit has reached the far end:
  // pout[WIDTH-1] for MSB_FIRST, pout[0] otherwise.
  always_comb begin
    base = (start || state_q == IDLE) ? '0 : sr_q;
    sr_d = MSB_FIRST ? {base[WIDTH-2:0], sin} : {sin, base[WIDTH-1:1]};
    last = (state_q == SHIFT) && !start && (cnt_q == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      pout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;

      if (start) begin
        // A start seen while a frame is open throws that partial frame away.
        abort_q <= (state_q == SHIFT);
        state_q <= SHIFT;
        cnt_q   <= CW'(1);
        sr_q    <= sr_d;
      end else if (state_q == SHIFT) begin
        sr_q <= sr_d;
        if (last) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      // Holding register. A word completing on the same edge that the
      // current word is accepted replaces it with no gap and no overrun.
      if (last) begin
        if (!valid_q || ready) begin
          pout_q  <= sr_d;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign pout    = pout_q;
  assign valid   = valid_q;
  assign busy    = (state_q == SHIFT);
  assign overrun = overrun_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_sipo_deframer.sv
`timescale 1ns/1ps
module tb_sipo_deframer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b0, start = 1'b0, ready = 1'b0;
  logic [W-1:0] pout_m, pout_l;
  logic valid_m, busy_m, ovr_m, abt_m;
  logic valid_l, busy_l, ovr_l, abt_l;

  int checks = 0;
  int errors = 0;

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .sin(sin), .start(start), .pout(pout_m),
    .valid(valid_m), .ready(ready), .busy(busy_m), .overrun(ovr_m), .abort(abt_m));

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .start(start), .pout(pout_l),
    .valid(valid_l), .ready(ready), .busy(busy_l), .overrun(ovr_l), .abort(abt_l));

  always #5 clk = ~clk;

  // Reference model: the open frame is a list of received bits; words are
  // formed by placing list element i at its bit position.
  bit           bits[$];
  logic [W-1:0] e_pm, e_pl;
  bit           e_v, e_ovr, e_abt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("pout_msb",  32'(pout_m),  32'(e_pm));
    chk("pout_lsb",  32'(pout_l),  32'(e_pl));
    chk("valid",     32'(valid_m), 32'(e_v));
    chk("valid_lsb", 32'(valid_l), 32'(e_v));
    chk("busy",      32'(busy_m),  32'(bits.size() > 0));
    chk("busy_lsb",  32'(busy_l),  32'(bits.size() > 0));
    chk("overrun",   32'(ovr_m),   32'(e_ovr));
    chk("ovr_lsb",   32'(ovr_l),   32'(e_ovr));
    chk("abort",     32'(abt_m),   32'(e_abt));
    chk("abort_lsb", 32'(abt_l),   32'(e_abt));
  endtask

  task automatic model_reset();
    bits.delete();
    e_pm = '0; e_pl = '0; e_v = 0; e_ovr = 0; e_abt = 0;
  endtask

  // Drive one cycle of inputs, let one edge pass, update the model, check.
  task automatic step(input bit s, input bit st, input bit rd);
    bit done;
    logic [W-1:0] wm, wl;
    sin = s; start = st; ready = rd;
    @(posedge clk);
    done = 0; e_ovr = 0; e_abt = 0; wm = '0; wl = '0;
    if (st) begin
      if (bits.size() > 0) e_abt = 1;
      bits.delete();
      bits.push_back(s);
    end else if (bits.size() > 0) begin
      bits.push_back(s);
      if (bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bits[i];
          wl[i]     = bits[i];
        end
        done = 1;
        bits.delete();
      end
    end
    if (done) begin
      if (!e_v || rd) begin e_pm = wm; e_pl = wl; e_v = 1; end
      else e_ovr = 1;
    end else if (e_v && rd) begin
      e_v = 0;
    end
    #1;
    chk_all();
  endtask

  // Send one frame MSB of w first, with ready held at rd.
  task automatic frame(input logic [W-1:0] w, input bit rd);
    for (int i = W-1; i >= 0; i--) step(w[i], i == W-1, rd);
  endtask

  initial begin
    model_reset();
    #2;
    chk_all();  // reset state while rst held
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic frame 1010; the LSB-first instance sees 0101.
    frame(4'b1010, 1'b0);
    chk("basic_msb", 32'(pout_m), 32'h a);
    chk("basic_lsb", 32'(pout_l), 32'h 5);
    step(0, 0, 1);
    chk("basic_accept", 32'(valid_m), 32'h0);

    // Back-to-back frames, ready held high.
    frame(4'b1010, 1'b1);
    chk("b2b_first", 32'(pout_m), 32'h a);
    frame(4'b0101, 1'b1);
    chk("b2b_second", 32'(pout_m), 32'h5);
    step(0, 0, 1);

    // Overrun: the second word is dropped and the first is kept.
    frame(4'b1100, 1'b0);
    frame(4'b0011, 1'b0);
    chk("ovr_pulse", 32'(ovr_m), 32'h1);
    chk("ovr_hold", 32'(pout_m), 32'hc);
    step(0, 0, 1);
    chk("ovr_accept", 32'(valid_m), 32'h0);

    // Same-edge accept and replace.
    frame(4'b1111, 1'b0);
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0); step(1, 0, 1);
    chk("same_edge_pout", 32'(pout_m), 32'h1);
    chk("same_edge_valid", 32'(valid_m), 32'h1);
    chk("same_edge_ovr", 32'(ovr_m), 32'h0);
    step(0, 0, 1);

    // Abort at bit 2, then the restarted frame is 1101.
    step(0, 1, 0); step(1, 0, 0);
    step(1, 1, 0);
    chk("abort_pulse", 32'(abt_m), 32'h1);
    step(1, 0, 0);
    chk("abort_once", 32'(abt_m), 32'h0);
    step(0, 0, 0); step(1, 0, 0);
    chk("abort_word", 32'(pout_m), 32'hd);

    // Reset mid-frame clears everything immediately.
    step(1, 1, 0); step(0, 0, 0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk_all();
    chk("rst_valid", 32'(valid_m), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    chk("rst_no_start", 32'(valid_m), 32'h0);

    // Randomized traffic: occasional early starts, random ready.
    for (int n = 0; n < 2000; n++) begin
      bit st;
      st = (bits.size() > 0) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) != 0);
      step(1'($urandom), st, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
